// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the ranged LFSR generator: FSM state
//                encoding, reference feedback masks for common widths and
//                the single-step LFSR helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Widest LFSR supported by the helper function.
  localparam int c_MAX_W = 16;

  // Maximal-length feedback masks. Bit i set means lfsr[i] feeds the XOR,
  // so bit i corresponds to the polynomial term x^(i+1).
  localparam logic [7:0]  c_TAPS_W8  = 8'hB8;     // x^8+x^6+x^5+x^4+1
  localparam logic [9:0]  c_TAPS_W10 = 10'h240;   // x^10+x^7+1
  localparam logic [11:0] c_TAPS_W12 = 12'h829;   // x^12+x^6+x^4+x+1
  localparam logic [15:0] c_TAPS_W16 = 16'hD008;  // x^16+x^15+x^13+x^4+1

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One Fibonacci step. Callers zero-extend a narrower register into the
  // c_MAX_W-bit argument and keep only their low WIDTH bits of the result;
  // the bit shifted past WIDTH-1 is then simply discarded.
  function automatic logic [c_MAX_W-1:0] lfsr_next(
    input logic [c_MAX_W-1:0] state,
    input logic [c_MAX_W-1:0] taps
  );
    lfsr_next = {state[c_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_range_gen_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mod_divider
//  Description : Restoring sequential divider returning only the remainder.
//                One dividend bit (MSB first) is consumed per clock, so a
//                conversion takes DIVIDEND_W cycles after the start edge.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk         system clock
//    rst         synchronous reset, active-high
//    i_start     load dividend/divisor and begin (ignored-safe while idle)
//    i_dividend  dividend, captured on the start edge
//    i_divisor   divisor, captured on the start edge
//    o_done      high during the cycle of the final iteration; o_rem holds
//                the final remainder from the following cycle onward
//    o_rem       remainder register
// ============================================================================
module seq_mod_divider
  import lfsr_pkg::*;
#(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_done,
  output logic [DIVISOR_W-1:0]  o_rem
);

  localparam int c_CNT_W = $clog2(DIVIDEND_W);

  logic [DIVIDEND_W-1:0] r_dividend;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_run;

  logic [DIVISOR_W:0]    w_trial;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_rem_next;

  // Partial remainder shifted left with the next dividend bit appended.
  // One extra bit keeps the shift lossless even if the divisor is the
  // largest representable value.
  assign w_trial    = {r_rem, r_dividend[DIVIDEND_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_divisor});
  assign w_rem_next = w_ge ? DIVISOR_W'(w_trial - {1'b0, r_divisor})
                           : DIVISOR_W'(w_trial);

  assign o_done = r_run && (r_cnt == c_CNT_W'(DIVIDEND_W - 1));
  assign o_rem  = r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_run      <= 1'b0;
    end else if (i_start) begin
      r_dividend <= i_dividend;
      r_divisor  <= i_divisor;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_run      <= 1'b1;
    end else if (r_run) begin
      r_rem      <= w_rem_next;
      r_dividend <= {r_dividend[DIVIDEND_W-2:0], 1'b0};
      r_cnt      <= r_cnt + c_CNT_W'(1);
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule : seq_mod_divider
`default_nettype wire

// File: rtl/lfsr_range_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_range_gen
//  Description : Seedable Fibonacci LFSR with zero-state guard, plus a
//                request/valid front end that maps a captured LFSR value
//                onto the inclusive range [min, max] using a sequential
//                remainder (no combinational divider).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk           system clock
//    rst           synchronous reset, active-high, overrides everything
//    i_step_en     advance the LFSR one step this cycle
//    i_seed_load   load i_seed_in (or SEED if it is zero); beats i_step_en
//    i_seed_in     seed value
//    i_req         request a ranged sample (sampled only when idle)
//    i_min_in      inclusive lower bound
//    i_max_in      inclusive upper bound
//    o_busy        conversion in progress, requests are dropped
//    o_rand_valid  one-cycle pulse qualifying o_rand_out / o_range_err
//    o_rand_out    ranged sample, held until the next pulse
//    o_range_err   max < min at capture (o_rand_out then equals min)
//    o_lfsr_state  current LFSR register
// ============================================================================
module lfsr_range_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h001,
  parameter int               OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step_en,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_req,
  input  logic [OUT_W-1:0] i_min_in,
  input  logic [OUT_W-1:0] i_max_in,
  output logic             o_busy,
  output logic             o_rand_valid,
  output logic [OUT_W-1:0] o_rand_out,
  output logic             o_range_err,
  output logic [WIDTH-1:0] o_lfsr_state
);

  // --------------------------------------------------------------------------
  // LFSR
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (i_seed_load) begin
      // An all-zero seed would lock the register, so substitute SEED.
      r_lfsr <= (i_seed_in == '0) ? SEED : i_seed_in;
    end else if (i_step_en) begin
      r_lfsr <= WIDTH'(lfsr_next(c_MAX_W'(r_lfsr), c_MAX_W'(TAPS)));
    end
  end

  assign o_lfsr_state = r_lfsr;

  // --------------------------------------------------------------------------
  // Request capture and range computation
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic             r_busy;
  logic             r_valid;
  logic [OUT_W-1:0] r_rand_out;
  logic             r_range_err;
  logic [OUT_W-1:0] r_min;
  logic             r_err_cap;

  logic             w_accept;
  logic [OUT_W:0]   w_range;
  logic             w_range_err;
  logic             w_div_done;
  logic [OUT_W:0]   w_rem;

  assign w_accept = (r_state == IDLE) && i_req;

  // Span is computed one bit wider than the bounds so the full range
  // (0 .. 2^OUT_W-1) yields 2^OUT_W rather than wrapping to zero.
  assign w_range     = {1'b0, i_max_in} - {1'b0, i_min_in} + (OUT_W + 1)'(1);
  assign w_range_err = (i_max_in < i_min_in);

  // The divider captures the pre-update LFSR value on the accepting edge,
  // so the LFSR is free to keep stepping during the conversion.
  seq_mod_divider #(
    .DIVIDEND_W (WIDTH),
    .DIVISOR_W  (OUT_W + 1)
  ) u_divider (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept),
    .i_dividend (r_lfsr),
    .i_divisor  (w_range),
    .o_done     (w_div_done),
    .o_rem      (w_rem)
  );

  // --------------------------------------------------------------------------
  // Conversion sequencer and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_rand_out  <= '0;
      r_range_err <= 1'b0;
      r_min       <= '0;
      r_err_cap   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_min     <= i_min_in;
            r_err_cap <= w_range_err;
            r_busy    <= 1'b1;
            r_state   <= DIV;
          end
        end
        DIV: begin
          // w_div_done flags the final iteration; the remainder is settled
          // by the time DONE executes.
          if (w_div_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // rem < range, so min + rem never exceeds max in the valid case.
          r_rand_out  <= r_err_cap ? r_min
                                   : OUT_W'({1'b0, r_min} + w_rem);
          r_range_err <= r_err_cap;
          r_valid     <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_rand_valid = r_valid;
  assign o_rand_out   = r_rand_out;
  assign o_range_err  = r_range_err;

endmodule : lfsr_range_gen
`default_nettype wire

// File: tb/tb_lfsr_range_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_range_gen
//  Description : Directed self-checking bench for lfsr_range_gen with a
//                scoreboard of expected ranged samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_range_gen;

  logic       clk;
  logic       rst;
  logic       i_step_en;
  logic       i_seed_load;
  logic [9:0] i_seed_in;
  logic       i_req;
  logic [9:0] i_min_in;
  logic [9:0] i_max_in;
  logic       o_busy;
  logic       o_rand_valid;
  logic [9:0] o_rand_out;
  logic       o_range_err;
  logic [9:0] o_lfsr_state;

  lfsr_range_gen #(
    .WIDTH (10),
    .TAPS  (10'h240),
    .SEED  (10'h001),
    .OUT_W (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_step_en    (i_step_en),
    .i_seed_load  (i_seed_load),
    .i_seed_in    (i_seed_in),
    .i_req        (i_req),
    .i_min_in     (i_min_in),
    .i_max_in     (i_max_in),
    .o_busy       (o_busy),
    .o_rand_valid (o_rand_valid),
    .o_rand_out   (o_rand_out),
    .o_range_err  (o_range_err),
    .o_lfsr_state (o_lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] out;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference for x^10+x^7+1: feedback from bits 9 and 6.
  function automatic logic [9:0] m_next(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (o_rand_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Drives one request; optionally steps the LFSR on the accepting edge and
  // pokes req while busy. Checks latency, busy and pulse width.
  task automatic conv(input logic [9:0] mn, input logic [9:0] mx,
                      input logic [9:0] eo, input logic ee,
                      input logic step, input logic poke,
                      input logic [9:0] exp_lfsr);
    int   cyc;
    exp_t e;
    i_min_in  = mn;
    i_max_in  = mx;
    i_req     = 1'b1;
    i_step_en = step;
    e.out = eo;
    e.err = ee;
    sb.push_back(e);
    tick();
    i_req     = 1'b0;
    i_step_en = 1'b0;
    check("busy_after_accept", {31'd0, o_busy}, 1);
    check("lfsr_after_accept", {22'd0, o_lfsr_state}, {22'd0, exp_lfsr});
    cyc = 0;
    if (poke) begin
      tick();
      i_req = 1'b1;
      tick();
      i_req = 1'b0;
      cyc = 2;
    end
    wait_valid(cyc, cyc);
    check("latency", cyc, 11);
    check("busy_at_valid", {31'd0, o_busy}, 0);
    tick();
    check("valid_pulse_width", {31'd0, o_rand_valid}, 0);
  endtask

  // Scoreboard consumer: compare every valid pulse against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && o_rand_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, o_rand_valid}, 0);
        end else begin
          e = sb.pop_front();
          check("rand_out", {22'd0, o_rand_out}, {22'd0, e.out});
          check("range_err", {31'd0, o_range_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    logic [9:0] m;
    int         c;
    exp_t       e;
    rst         = 1'b1;
    i_step_en   = 1'b0;
    i_seed_load = 1'b0;
    i_seed_in   = '0;
    i_req       = 1'b0;
    i_min_in    = '0;
    i_max_in    = '0;
    tick();
    tick();
    check("reset_lfsr", {22'd0, o_lfsr_state}, 1);
    check("reset_busy", {31'd0, o_busy}, 0);
    check("reset_valid", {31'd0, o_rand_valid}, 0);
    check("reset_rand_out", {22'd0, o_rand_out}, 0);
    check("reset_range_err", {31'd0, o_range_err}, 0);
    rst = 1'b0;

    // Free-running steps from SEED: 001,002,004,008,010,020,040,081.
    m = 10'h001;
    i_step_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      m = m_next(m);
      check("lfsr_step", {22'd0, o_lfsr_state}, {22'd0, m});
    end
    i_step_en = 1'b0;
    check("lfsr_step_final", {22'd0, o_lfsr_state}, 32'h081);
    check("idle_busy", {31'd0, o_busy}, 0);

    // Zero seed falls back to SEED; seed_load beats step_en.
    i_seed_load = 1'b1;
    i_seed_in   = 10'h000;
    tick();
    check("zero_seed_guard", {22'd0, o_lfsr_state}, 1);
    i_seed_in = 10'h3FF;
    i_step_en = 1'b1;
    tick();
    check("seed_beats_step", {22'd0, o_lfsr_state}, 32'h3FF);
    i_seed_load = 1'b0;
    i_step_en   = 1'b0;

    // 1023 mod 151 = 117 -> 25 + 117 = 142.
    conv(10'd25, 10'd175, 10'd142, 1'b0, 1'b0, 1'b0, 10'h3FF);
    // Degenerate range of one value.
    conv(10'd50, 10'd50, 10'd50, 1'b0, 1'b0, 1'b0, 10'h3FF);
    // Inverted bounds: min returned with error flag, same latency.
    conv(10'd100, 10'd20, 10'd100, 1'b1, 1'b0, 1'b0, 10'h3FF);
    // Full span: divisor 1024 must not wrap. LFSR steps on the accepting
    // edge but the operand is the pre-update 3FF; req poked while busy.
    conv(10'd0, 10'd1023, 10'd1023, 1'b0, 1'b1, 1'b1, m_next(10'h3FF));
    for (int i = 0; i < 15; i++) tick();

    // Reset four cycles after accept aborts with no pulse.
    i_min_in = 10'd0;
    i_max_in = 10'd9;
    i_req    = 1'b1;
    tick();
    i_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, o_busy}, 0);
    check("abort_valid", {31'd0, o_rand_valid}, 0);
    check("abort_rand_out", {22'd0, o_rand_out}, 0);
    check("abort_range_err", {31'd0, o_range_err}, 0);
    check("abort_lfsr", {22'd0, o_lfsr_state}, 1);
    for (int i = 0; i < 15; i++) tick();

    // Next request after the abort: 1 mod 10 = 1 -> 11.
    conv(10'd10, 10'd19, 10'd11, 1'b0, 1'b0, 1'b0, 10'h001);

    // Held req gives back-to-back conversions WIDTH+2 cycles apart.
    e.out = 10'd1;
    e.err = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    i_min_in = 10'd0;
    i_max_in = 10'd6;
    i_req    = 1'b1;
    tick();
    wait_valid(0, c);
    check("b2b_first_latency", c, 11);
    tick();
    wait_valid(1, c);
    check("b2b_spacing", c, 12);
    i_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("b2b_busy_after", {31'd0, o_busy}, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule : tb_lfsr_range_gen
`default_nettype wire

// File: doc/lfsr_range_gen.md
Name: lfsr_range_gen

Overview:
Parametrised pseudo-random source for game logic such as obstacle heights and spawn gaps. It is a configurable-width Fibonacci LFSR with runtime seeding and zero-state lock-up protection. Each request maps the LFSR value onto a runtime inclusive range [min_in, max_in] with a multi-cycle sequential modulo, so no combinational divider is built. It sits between the game controller and the sprite/obstacle generators and uses a req/valid handshake.

Parameters:
WIDTH, 10, LFSR width in bits (4..16).
TAPS, 10'h240, feedback mask; bit i set means lfsr[i] is XORed into the feedback. The default is x^10+x^7+1, period 1023.
SEED, 10'h001, reset and fallback seed; must be non-zero.
OUT_W, 10, width of min_in/max_in/rand_out.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
step_en  input  1  advance LFSR one step this cycle (game tick enable)
seed_load  input  1  load seed_in into LFSR this cycle
seed_in  input  WIDTH  seed value
req  input  1  request a ranged sample
min_in  input  OUT_W  range lower bound, inclusive
max_in  input  OUT_W  range upper bound, inclusive
busy  output  1  conversion in progress; req ignored
rand_valid  output  1  one-cycle pulse, rand_out/range_err valid
rand_out  output  OUT_W  ranged sample, held until next rand_valid
range_err  output  1  qualified by rand_valid; max_in < min_in at capture
lfsr_state  output  WIDTH  current LFSR register

Behaviour:
- Single clock is clk. Reset is synchronous, active-high on rst, and overrides everything. On reset: lfsr_state=SEED, state=IDLE, busy=0, rand_valid=0, rand_out=0, range_err=0. Reset mid-conversion aborts it with no rand_valid.
- LFSR step: next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- LFSR priority per cycle: seed_load > step_en > hold.
- seed_in==0 loads SEED instead (lock-up guard).
- The LFSR keeps stepping during a conversion; the operand is a captured copy.
- FSM states:
  - IDLE: req=1 accepts the request. Capture operand=lfsr_state (pre-update value of the same edge), and capture min_in and max_in. Go to DIV, busy=1.
  - DIV: restoring division, one dividend bit per cycle, WIDTH cycles. Divisor: range = max - min + 1, computed at OUT_W+1 bits. Remainder register is OUT_W+1 bits.
  - DONE: rand_out <= min + rem (rem < range, so the result ≤ max and fits OUT_W). rand_valid=1 for exactly one cycle. busy=0. Return to IDLE.
- Latency: rand_valid is high in the cycle following the (WIDTH+1)th rising edge after the accepting edge. The latency is fixed for all operands, including error cases.
- req while busy=1 is dropped (no queue). req is level-sampled only in IDLE, so holding req high gives back-to-back conversions WIDTH+2 cycles apart.
- max==min: range=1, rem=0, rand_out=min.
- max<min: the divider still runs (result discarded). rand_out=min, range_err=1 with rand_valid.
- Full span (min=0, max=2^OUT_W-1): range=2^OUT_W needs the OUT_W+1-bit divisor and must not wrap to 0.

Decomposition:
- Package lfsr_pkg holds:
  - FSM state enum (IDLE, DIV, DONE).
  - Default tap masks for widths 8/10/12/16.
  - Function lfsr_next(state, taps).
- Sub-module seq_mod_divider handles the sequential remainder. Parameters: DIVIDEND_W, DIVISOR_W. Handshake: start/done. Outputs the remainder.
- lfsr_range_gen owns the LFSR, seeding, capture and the output registers.

Test Plan:
- Reset, then step_en=1 for 7 cycles from SEED=1 → lfsr_state sequence 001,002,004,008,010,020,040,081. busy=0, rand_out=0.
- seed_load with seed_in=0 → lfsr_state=SEED (001). seed_load and step_en together with seed_in=3FF → lfsr_state=3FF (load wins).
- With state 3FF, req, min=25, max=175 → range 151, 1023 mod 151=117. Exactly 11 edges later: rand_valid pulse, rand_out=142, range_err=0.
- min=max=50 → rand_out=50. min=100, max=20 → rand_out=100, range_err=1, same latency.
- min=0, max=1023, operand 3FF → rand_out=1023 (no divisor wrap). Pulse req during busy → no extra rand_valid.
- Assert rst 4 cycles after accept → no rand_valid, all outputs at reset values. Next req completes normally.
